fetch_unit: RTL and testbench

Instruction fetch stage for the single-cycle ARM processor. Holds the program counter, fetches instruction words from instruction memory over a req/ack handshake, and presents one instruction at a time to the controller/datapath. Consumes the branch decision (PCSrc) and branch target (Result) that the controller/datapath produce, and provides PC+8 for R15 reads.

---
 rtl/arm_pkg.sv | 20 ++
 rtl/fetch_prefetch_buf.sv | 29 ++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared types and constants for the single-cycle ARM core's fetch path.
// fetch_unit uses fetch_state_t; DRAIN is reached only when built with FETCH_PREFETCH_EN.
package arm_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] WORD_BYTES       = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Clears the low address bits so a branch target always lands on a word.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~(WORD_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_prefetch_buf.sv
// One-entry prefetch holding register. Flush has priority over load, and load over pop.
// It is instantiated by fetch_unit only when FETCH_PREFETCH_EN is defined.
module fetch_prefetch_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  // NOTE: the data register has no reset. Nothing reads it while valid is low.
  always_ff @(posedge clk) begin
    if (load) dout <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds PC, fetches over a req/ack handshake and presents one instruction.
// Optional feature macro FETCH_PREFETCH_EN adds a one-entry prefetch of PC+4 plus a DRAIN state.
module fetch_unit
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRData,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8,
  input  logic        Advance,
  input  logic        PCSrc,
  input  logic [31:0] Result
);

  fetch_state_t state;

  logic        retire;
  logic        ack_ok;
  logic [31:0] seq_pc;
  logic [31:0] redirect_pc;
  logic [31:0] next_pc;

  // NOTE: continuous assigns / always_comb for derived values, non-blocking <= only inside always_ff.
  assign retire      = Advance && InstrValid && (state == VALID);
  assign ack_ok      = IMemReq && IMemAck;
  assign seq_pc      = PC + WORD_BYTES;
  assign redirect_pc = word_align(Result);
  assign next_pc     = PCSrc ? redirect_pc : seq_pc;
  assign PCPlus8     = PC + (WORD_BYTES << 1);

`ifdef FETCH_PREFETCH_EN
  logic        buf_load;
  logic        buf_pop;
  logic        buf_flush;
  logic        buf_valid;
  logic [31:0] buf_data;

  // A returned prefetch word is buffered unless it is consumed or dropped in the same cycle.
  assign buf_load  = (state == VALID) && ack_ok && !retire;
  assign buf_pop   = retire && !PCSrc && buf_valid;
  assign buf_flush = retire && PCSrc;

  fetch_prefetch_buf u_prefetch_buf (
    .clk   (clk),
    .reset (reset),
    .load  (buf_load),
    .pop   (buf_pop),
    .flush (buf_flush),
    .din   (IMemRData),
    .dout  (buf_data),
    .valid (buf_valid)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= START;
      PC         <= RESET_PC;
      IMemAddr   <= RESET_PC;
      IMemReq    <= 1'b0;
      Instr      <= '0;
      InstrValid <= 1'b0;
    end else begin
      case (state)
        START: begin
          state    <= FETCH;
          IMemReq  <= 1'b1;
          IMemAddr <= PC;
        end

        FETCH: begin
          if (ack_ok) begin
            Instr      <= IMemRData;
            InstrValid <= 1'b1;
            state      <= VALID;
`ifdef FETCH_PREFETCH_EN
            IMemAddr   <= seq_pc;
`else
            IMemReq    <= 1'b0;
`endif
          end
        end

        VALID: begin
`ifdef FETCH_PREFETCH_EN
          if (retire && !PCSrc && (buf_valid || ack_ok)) begin
            // The next word is already here (buffered or arriving now): retire back to back.
            Instr    <= buf_valid ? buf_data : IMemRData;
            PC       <= seq_pc;
            IMemReq  <= 1'b1;
            IMemAddr <= PCPlus8;
          end else if (retire && !PCSrc) begin
            PC         <= seq_pc;
            InstrValid <= 1'b0;
            state      <= FETCH;
            IMemReq    <= 1'b1;
            IMemAddr   <= seq_pc;
          end else if (retire) begin
            PC         <= redirect_pc;
            InstrValid <= 1'b0;
            if (IMemReq && !IMemAck) begin
              state <= DRAIN;
            end else begin
              state    <= FETCH;
              IMemReq  <= 1'b1;
              IMemAddr <= redirect_pc;
            end
          end else if (ack_ok) begin
            IMemReq <= 1'b0;
          end
`else
          if (retire) begin
            PC         <= next_pc;
            IMemAddr   <= next_pc;
            IMemReq    <= 1'b1;
            InstrValid <= 1'b0;
            state      <= FETCH;
          end
`endif
        end

        default: begin
`ifdef FETCH_PREFETCH_EN
          // DRAIN keeps the stale request up until it is acked, then drops the word.
          if (ack_ok) begin
            IMemAddr <= PC;
            state    <= FETCH;
          end
`else
          state   <= START;
          IMemReq <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a simple ack-delay instruction memory model.
// Sequence is chosen by FETCH_PREFETCH_EN to match the build of the design.
module tb_fetch_unit;
  import arm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemRData;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus8;
  logic        Advance;
  logic        PCSrc;
  logic [31:0] Result;

  int checks   = 0;
  int failures = 0;

  int unsigned ack_delay = 0;
  int unsigned wait_cnt  = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemAck    (IMemAck),
    .IMemRData  (IMemRData),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .PC         (PC),
    .PCPlus8    (PCPlus8),
    .Advance    (Advance),
    .PCSrc      (PCSrc),
    .Result     (Result)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'hE3A0_1005;
      32'h4:   return 32'hE281_1001;
      default: return 32'hE000_0000 | a;
    endcase
  endfunction

  // Memory model: acks after the request has been held for ack_delay cycles.
  assign IMemAck   = IMemReq && (wait_cnt >= ack_delay);
  assign IMemRData = mem_word(IMemAddr);

  always @(posedge clk) begin
    if (!IMemReq || IMemAck) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    Advance = 1'b0;
    PCSrc   = 1'b0;
    Result  = '0;
    tick();
    tick();
    check("rst_req",   32'(IMemReq), 32'd0);
    check("rst_pc",    PC, 32'h0);
    check("rst_addr",  IMemAddr, 32'h0);
    check("rst_valid", 32'(InstrValid), 32'd0);
    check("rst_instr", Instr, 32'h0);
    reset   = 1'b0;
    Advance = 1'b1;
    tick();
    check("first_req",  32'(IMemReq), 32'd1);
    check("first_addr", IMemAddr, 32'h0);
    check("pcplus8",    PCPlus8, 32'h8);

`ifndef FETCH_PREFETCH_EN
    tick();
    check("i0_valid", 32'(InstrValid), 32'd1);
    check("i0_instr", Instr, 32'hE3A0_1005);
    check("i0_noreq", 32'(IMemReq), 32'd0);
    tick();
    check("a1_addr",  IMemAddr, 32'h4);
    check("a1_pc",    PC, 32'h4);
    check("a1_valid", 32'(InstrValid), 32'd0);
    tick();
    check("i1_instr", Instr, 32'hE281_1001);
    tick();
    check("a2_addr",  IMemAddr, 32'h8);
    Advance = 1'b0;
    tick();
    check("i2_instr", Instr, mem_word(32'h8));

    // Slow memory: request must hold its address until the ack on the 4th cycle.
    ack_delay = 3;
    Advance   = 1'b1;
    tick();
    Advance = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("slow_addr",  IMemAddr, 32'hC);
      check("slow_req",   32'(IMemReq), 32'd1);
      check("slow_valid", 32'(InstrValid), 32'd0);
      tick();
    end
    check("slow_valid_after", 32'(InstrValid), 32'd1);
    check("slow_instr",       Instr, mem_word(32'hC));

    // Taken branch with unaligned target.
    ack_delay = 2;
    Advance   = 1'b1;
    PCSrc     = 1'b1;
    Result    = 32'h103;
    tick();
    check("br_addr", IMemAddr, 32'h100);
    check("br_pc",   PC, 32'h100);
    // Advance and PCSrc while nothing valid must be ignored.
    Result = 32'h200;
    tick();
    Advance = 1'b0;
    PCSrc   = 1'b0;
    check("ign_pc",   PC, 32'h100);
    check("ign_addr", IMemAddr, 32'h100);
    tick();
    tick();
    check("br_instr", Instr, mem_word(32'h100));
    check("br_pc2",   PC, 32'h100);

    // Reset in the middle of a long fetch at 0x40, with an ack landing on the reset edge.
    ack_delay = 20;
    Advance   = 1'b1;
    PCSrc     = 1'b1;
    Result    = 32'h40;
    tick();
    Advance = 1'b0;
    PCSrc   = 1'b0;
    check("mid_pc", PC, 32'h40);
    tick();
    ack_delay = 0;
    reset     = 1'b1;
    tick();
    check("mr_req",   32'(IMemReq), 32'd0);
    check("mr_pc",    PC, 32'h0);
    check("mr_addr",  IMemAddr, 32'h0);
    check("mr_valid", 32'(InstrValid), 32'd0);
    check("mr_instr", Instr, 32'h0);
    reset = 1'b0;
    tick();
    check("mr_first_req",  32'(IMemReq), 32'd1);
    check("mr_first_addr", IMemAddr, 32'h0);
`else
    // Zero-wait memory with prefetch: one new instruction every cycle.
    for (int k = 0; k < 4; k++) begin
      tick();
      check("pf_valid", 32'(InstrValid), 32'd1);
      check("pf_instr", Instr, mem_word(32'(k) * 32'd4));
      check("pf_pc",    PC, 32'(k) * 32'd4);
    end
    // Now PC=0xC with prefetch of 0x10 in flight; delay it and redirect.
    ack_delay = 3;
    PCSrc     = 1'b1;
    Result    = 32'h80;
    tick();
    Advance = 1'b0;
    PCSrc   = 1'b0;
    check("dr_addr",  IMemAddr, 32'h10);
    check("dr_pc",    PC, 32'h80);
    for (int i = 0; i < 3; i++) begin
      check("dr_valid", 32'(InstrValid), 32'd0);
      tick();
    end
    ack_delay = 0;
    check("dr_fetch_addr", IMemAddr, 32'h80);
    check("dr_no_stale",   Instr, mem_word(32'hC));
    tick();
    check("dr_instr", Instr, mem_word(32'h80));
    check("dr_valid2", 32'(InstrValid), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
